// File: rtl/button_move_ctrl.sv
// Debounces four pushbuttons and turns each debounced press into exactly one
// move request, handed to the game FSM with a valid/ready handshake.
module button_move_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       BTN_RIGHT,
  input  logic       BTN_LEFT,
  input  logic       BTN_TOP,
  input  logic       BTN_BOT,
  input  logic       game_over,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic [3:0] btn_state,
  output logic [1:0] ctrl_state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    PEND     = 2'b01,
    WAIT_REL = 2'b10
  } state_t;

  state_t        state;
  logic [3:0]    raw_btn;
  logic [3:0]    sync_1;
  logic [3:0]    sync_2;
  logic [3:0]    btn_prev;
  logic [3:0]    rise;
  logic [1:0]    req_dir;
  logic [CW-1:0] cnt [4];

  assign raw_btn    = {BTN_BOT, BTN_TOP, BTN_LEFT, BTN_RIGHT};
  assign ctrl_state = state;
  assign rise       = btn_state & ~btn_prev;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= raw_btn;
      sync_2 <= sync_1;
    end
  end

  // The counter only advances while the synced level disagrees with the
  // accepted level; any agreement restarts the stability window.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      btn_state <= '0;
      btn_prev  <= '0;
    end else begin
      btn_prev <= btn_state;
      for (int i = 0; i < 4; i++) begin
        if (sync_2[i] == btn_state[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          cnt[i]       <= '0;
          btn_state[i] <= ~btn_state[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    req_dir = 2'b00;
    if (rise[0])      req_dir = 2'b00;
    else if (rise[1]) req_dir = 2'b01;
    else if (rise[2]) req_dir = 2'b10;
    else if (rise[3]) req_dir = 2'b11;
  end

  // A transfer and a game_over drop both end in WAIT_REL, so no held
  // button can ever produce a second move.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      move_valid <= 1'b0;
      move_dir   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (|rise && !game_over) begin
            state      <= PEND;
            move_valid <= 1'b1;
            move_dir   <= req_dir;
          end
        end
        PEND: begin
          if (move_ready || game_over) begin
            state      <= WAIT_REL;
            move_valid <= 1'b0;
          end
        end
        WAIT_REL: begin
          if (btn_state == 4'b0000) state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          move_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
